// File: rtl/pool_pkg.sv
// Shared constants and FSM state encoding for the 6-sample averaging pool controller.
package pool_pkg;

    localparam int WIN         = 6;
    localparam int BRAM_RD_LAT = 1;
    localparam int DATA_W      = 8;
    localparam int SUM_W       = 16;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FETCH = 3'd1,
        DRAIN = 3'd2,
        WRITE = 3'd3,
        FIN   = 3'd4
    } state_t;

endpackage

// File: rtl/avg_pool_ctrl_avg.sv
// Combinational 6-input average: 16-bit sum followed by a truncating divide by 6.
module avg
    import pool_pkg::*;
(
    input  logic [WIN-1:0][DATA_W-1:0] i_samples,
    output logic [DATA_W-1:0]          o_avg
);

    // The largest possible sum (6 * 255) divided by 6 still fits in DATA_W bits.
    function automatic logic [DATA_W-1:0] f_div_win(input logic [SUM_W-1:0] sum);
        return DATA_W'(sum / SUM_W'(WIN));
    endfunction

    logic [SUM_W-1:0] w_sum;

    always_comb begin
        w_sum = '0;
        for (int i = 0; i < WIN; i++) begin
            w_sum = w_sum + SUM_W'(i_samples[i]);
        end
    end

    assign o_avg = f_div_win(w_sum);

endmodule

// File: rtl/avg_pool_ctrl.sv
// Sequences BRAM fetches of 6-sample windows through the avg datapath and writes
// one average per window to the destination BRAM.
module avg_pool_ctrl
    import pool_pkg::*;
#(
    parameter int ADDR_W = 10,
    parameter int CNT_W  = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] src_base,
    input  logic [ADDR_W-1:0] dst_base,
    input  logic [CNT_W-1:0]  num_win,
    output logic              busy,
    output logic              done,
    output logic              src_en,
    output logic [ADDR_W-1:0] src_addr,
    input  logic [DATA_W-1:0] src_dout,
    output logic              dst_we,
    output logic [ADDR_W-1:0] dst_addr,
    output logic [DATA_W-1:0] dst_din
);

    state_t              r_state;
    state_t              w_state_nxt;

    logic [2:0]          r_k;
    logic [CNT_W-1:0]    r_w;
    logic [ADDR_W-1:0]   r_src_base;
    logic [ADDR_W-1:0]   r_dst_base;
    logic [CNT_W-1:0]    r_num_win;
    logic [ADDR_W-1:0]   r_win_off;
    logic [DATA_W-1:0]   r_sample [WIN];

    logic                r_busy;
    logic                r_done;
    logic                r_src_en;
    logic [ADDR_W-1:0]   r_src_addr;
    logic                r_dst_we;
    logic [ADDR_W-1:0]   r_dst_addr;
    logic [DATA_W-1:0]   r_dst_din;

    logic                w_last_fetch;
    logic [2:0]          w_k_nxt;
    logic [CNT_W:0]      w_w_nxt;
    logic                w_more;
    logic [ADDR_W-1:0]   w_fetch_addr_nxt;
    logic [ADDR_W-1:0]   w_win_off_nxt;
    logic [WIN-1:0][DATA_W-1:0] w_avg_in;
    logic [DATA_W-1:0]   w_avg;

    assign w_last_fetch     = (r_k == 3'(WIN - 1));
    assign w_k_nxt          = r_k + 3'd1;
    assign w_w_nxt          = {1'b0, r_w} + (CNT_W + 1)'(1);
    assign w_more           = (w_w_nxt < {1'b0, r_num_win});
    assign w_fetch_addr_nxt = r_src_base + r_win_off + ADDR_W'(w_k_nxt);
    assign w_win_off_nxt    = r_win_off + ADDR_W'(WIN);

    // The last sample arrives during DRAIN, the same edge dst_din is registered,
    // so that lane takes the BRAM output directly instead of its sample register.
    always_comb begin
        for (int i = 0; i < WIN; i++) begin
            w_avg_in[i] = r_sample[i];
        end
        if (r_state == DRAIN) begin
            w_avg_in[WIN-1] = src_dout;
        end
    end

    avg u_avg (
        .i_samples (w_avg_in),
        .o_avg     (w_avg)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_state_nxt = (num_win != '0) ? FETCH : FIN;
                end
            end
            FETCH: begin
                if (w_last_fetch) begin
                    w_state_nxt = DRAIN;
                end
            end
            DRAIN:   w_state_nxt = WRITE;
            WRITE:   w_state_nxt = w_more ? FETCH : FIN;
            FIN:     w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_k        <= '0;
            r_w        <= '0;
            r_src_base <= '0;
            r_dst_base <= '0;
            r_num_win  <= '0;
            r_win_off  <= '0;
            for (int i = 0; i < WIN; i++) begin
                r_sample[i] <= '0;
            end
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_src_en   <= 1'b0;
            r_src_addr <= '0;
            r_dst_we   <= 1'b0;
            r_dst_addr <= '0;
            r_dst_din  <= '0;
        end else begin
            r_busy   <= (w_state_nxt != IDLE);
            r_done   <= (w_state_nxt == FIN);
            r_src_en <= (w_state_nxt == FETCH);
            r_dst_we <= (w_state_nxt == WRITE);

            case (r_state)
                IDLE: begin
                    if (start && (num_win != '0)) begin
                        r_src_base <= src_base;
                        r_dst_base <= dst_base;
                        r_num_win  <= num_win;
                        r_w        <= '0;
                        r_k        <= '0;
                        r_win_off  <= '0;
                        r_src_addr <= src_base;
                    end
                end
                FETCH: begin
                    for (int i = 0; i < WIN - 1; i++) begin
                        if (r_k == 3'(i + BRAM_RD_LAT)) begin
                            r_sample[i] <= src_dout;
                        end
                    end
                    if (!w_last_fetch) begin
                        r_k        <= w_k_nxt;
                        r_src_addr <= w_fetch_addr_nxt;
                    end
                end
                DRAIN: begin
                    r_sample[WIN-1] <= src_dout;
                    r_dst_addr      <= r_dst_base + ADDR_W'(r_w);
                    r_dst_din       <= w_avg;
                end
                WRITE: begin
                    r_w <= w_w_nxt[CNT_W-1:0];
                    if (w_more) begin
                        r_k        <= '0;
                        r_win_off  <= w_win_off_nxt;
                        r_src_addr <= r_src_base + w_win_off_nxt;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign busy     = r_busy;
    assign done     = r_done;
    assign src_en   = r_src_en;
    assign src_addr = r_src_addr;
    assign dst_we   = r_dst_we;
    assign dst_addr = r_dst_addr;
    assign dst_din  = r_dst_din;

endmodule

// File: tb/tb_avg_pool_ctrl.sv
// Scoreboard bench for avg_pool_ctrl: stimulus queues expected BRAM reads, writes and
// done pulses with their cycle stamps; a negedge monitor pops and compares them.
module tb_avg_pool_ctrl;

    localparam int ADDR_W = 10;
    localparam int CNT_W  = 10;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic [ADDR_W-1:0] src_base;
    logic [ADDR_W-1:0] dst_base;
    logic [CNT_W-1:0]  num_win;
    logic              busy;
    logic              done;
    logic              src_en;
    logic [ADDR_W-1:0] src_addr;
    logic [7:0]        src_dout = '0;
    logic              dst_we;
    logic [ADDR_W-1:0] dst_addr;
    logic [7:0]        dst_din;

    logic [7:0] src_mem [0:1023];
    logic [7:0] dst_mem [0:1023];

    int cyc    = 0;
    int n_chk  = 0;
    int n_fail = 0;

    typedef struct {
        int addr;
        int data;
        int cyc;
    } ev_t;

    ev_t rd_q[$];
    ev_t wr_q[$];
    int  done_q[$];
    ev_t mon_e;
    int  mon_d;

    avg_pool_ctrl #(.ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .src_base (src_base),
        .dst_base (dst_base),
        .num_win  (num_win),
        .busy     (busy),
        .done     (done),
        .src_en   (src_en),
        .src_addr (src_addr),
        .src_dout (src_dout),
        .dst_we   (dst_we),
        .dst_addr (dst_addr),
        .dst_din  (dst_din)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        if (src_en) src_dout <= src_mem[src_addr];
        if (dst_we) dst_mem[dst_addr] <= dst_din;
    end

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every DUT read, write and done pulse must match the head of its queue.
    always @(negedge clk) begin
        if (src_en) begin
            if (rd_q.size() == 0) begin
                n_chk++; n_fail++;
                $display("FAIL rd_unexpected: read of addr %0d at cycle %0d, none expected", src_addr, cyc);
            end else begin
                mon_e = rd_q.pop_front();
                chk("rd_addr", int'(src_addr), mon_e.addr);
                chk("rd_cycle", cyc, mon_e.cyc);
            end
        end
        if (dst_we) begin
            if (wr_q.size() == 0) begin
                n_chk++; n_fail++;
                $display("FAIL wr_unexpected: write %0d to addr %0d at cycle %0d, none expected", dst_din, dst_addr, cyc);
            end else begin
                mon_e = wr_q.pop_front();
                chk("wr_addr", int'(dst_addr), mon_e.addr);
                chk("wr_data", int'(dst_din), mon_e.data);
                chk("wr_cycle", cyc, mon_e.cyc);
            end
        end
        if (done) begin
            if (done_q.size() == 0) begin
                n_chk++; n_fail++;
                $display("FAIL done_unexpected: done at cycle %0d, none expected", cyc);
            end else begin
                mon_d = done_q.pop_front();
                chk("done_cycle", cyc, mon_d);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_rd(input int addr, input int c);
        ev_t e;
        e.addr = addr % 1024; e.data = 0; e.cyc = c;
        rd_q.push_back(e);
    endtask

    task automatic push_wr(input int addr, input int data, input int c);
        ev_t e;
        e.addr = addr % 1024; e.data = data; e.cyc = c;
        wr_q.push_back(e);
    endtask

    // Cycle T+j (after start is accepted at edge T) is seen by the monitor with cyc == t0+j.
    task automatic expect_job(input int sb, input int db, input int nw, input int avgs[4], input int t0);
        for (int w = 0; w < nw; w++) begin
            for (int k = 0; k < 6; k++) push_rd(sb + 6*w + k, t0 + 1 + 8*w + k);
            push_wr(db + w, avgs[w], t0 + 8*(w + 1));
        end
        done_q.push_back(t0 + 8*nw + 1);
    endtask

    task automatic launch(input int sb, input int db, input int nw, output int t0);
        src_base = ADDR_W'(sb);
        dst_base = ADDR_W'(db);
        num_win  = CNT_W'(nw);
        start    = 1'b1;
        t0       = cyc;
        tick();
        start    = 1'b0;
    endtask

    task automatic settle(input string name, input int t_end);
        while (cyc < t_end) tick();
        chk({name, "_reads_left"},  rd_q.size(),   0);
        chk({name, "_writes_left"}, wr_q.size(),   0);
        chk({name, "_done_left"},   done_q.size(), 0);
        chk({name, "_busy_idle"},   int'(busy),    0);
    endtask

    task automatic chk_outputs_zero(input string name);
        chk({name, "_busy"},     int'(busy),     0);
        chk({name, "_done"},     int'(done),     0);
        chk({name, "_src_en"},   int'(src_en),   0);
        chk({name, "_dst_we"},   int'(dst_we),   0);
        chk({name, "_src_addr"}, int'(src_addr), 0);
        chk({name, "_dst_addr"}, int'(dst_addr), 0);
        chk({name, "_dst_din"},  int'(dst_din),  0);
    endtask

    initial begin
        int t0;
        int avgs[4];

        for (int i = 0; i < 1024; i++) src_mem[i] = 8'd0;
        rst = 1'b1; start = 1'b0; src_base = '0; dst_base = '0; num_win = '0;
        repeat (3) tick();
        chk_outputs_zero("reset");
        rst = 1'b0;
        tick();
        chk_outputs_zero("post_reset");

        // Single window of 10s; a start during the done cycle must be ignored.
        for (int i = 0; i < 6; i++) src_mem[i] = 8'd10;
        launch(0, 5, 1, t0);
        avgs = '{10, 0, 0, 0};
        expect_job(0, 5, 1, avgs, t0);
        while (cyc < t0 + 9) tick();
        num_win = CNT_W'(1); start = 1'b1;
        tick();
        start = 1'b0;
        settle("single10", t0 + 14);
        chk("single10_mem", int'(dst_mem[5]), 10);

        // 1..6 averages to 3 (21/6 truncated).
        for (int i = 0; i < 6; i++) src_mem[200 + i] = 8'(i + 1);
        launch(200, 6, 1, t0);
        avgs = '{3, 0, 0, 0};
        expect_job(200, 6, 1, avgs, t0);
        settle("trunc", t0 + 12);

        // All 255: no overflow in the sum.
        for (int i = 0; i < 6; i++) src_mem[300 + i] = 8'd255;
        launch(300, 7, 1, t0);
        avgs = '{255, 0, 0, 0};
        expect_job(300, 7, 1, avgs, t0);
        settle("max", t0 + 12);
        chk("max_mem", int'(dst_mem[7]), 255);

        // Four windows over src[100+i]=i: sums 15,51,87,123 -> 2,8,14,20.
        for (int i = 0; i < 24; i++) src_mem[100 + i] = 8'(i);
        launch(100, 20, 4, t0);
        avgs = '{2, 8, 14, 20};
        expect_job(100, 20, 4, avgs, t0);
        settle("four", t0 + 36);
        chk("four_mem3", int'(dst_mem[23]), 20);

        // Zero windows: done at T+1, no BRAM traffic.
        launch(0, 0, 0, t0);
        done_q.push_back(t0 + 1);
        settle("zero", t0 + 5);

        // Two windows over src[400+i]=2i -> 5, 17; a second start at T+5 is ignored.
        for (int i = 0; i < 12; i++) src_mem[400 + i] = 8'(2 * i);
        launch(400, 40, 2, t0);
        avgs = '{5, 17, 0, 0};
        expect_job(400, 40, 2, avgs, t0);
        while (cyc < t0 + 5) tick();
        src_base = ADDR_W'(0); dst_base = ADDR_W'(90); num_win = CNT_W'(1); start = 1'b1;
        tick();
        start = 1'b0;
        settle("ignore", t0 + 20);

        // Source address wraps: 1021..1023 then 0..2; 3*30 + 3*60 = 270 -> 45.
        src_mem[1021] = 8'd30; src_mem[1022] = 8'd30; src_mem[1023] = 8'd30;
        src_mem[0] = 8'd60; src_mem[1] = 8'd60; src_mem[2] = 8'd60;
        launch(1021, 50, 1, t0);
        avgs = '{45, 0, 0, 0};
        expect_job(1021, 50, 1, avgs, t0);
        settle("wrap", t0 + 12);

        // Abort at T+12 of a 2-window job: window 0 (sum 252 -> 42) stays, no done.
        for (int i = 0; i < 12; i++) src_mem[500 + i] = 8'(12 * (i + 1));
        launch(500, 60, 2, t0);
        for (int k = 0; k < 6; k++) push_rd(500 + k, t0 + 1 + k);
        push_wr(60, 42, t0 + 8);
        for (int k = 0; k < 4; k++) push_rd(506 + k, t0 + 9 + k);
        while (cyc < t0 + 12) tick();
        rst = 1'b1;
        tick();
        chk_outputs_zero("abort");
        rst = 1'b0;
        settle("abort", t0 + 18);
        chk("abort_mem", int'(dst_mem[60]), 42);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
